// File: rtl/datapath_unpack_fifo.sv
// 192-bit word FIFO that unpacks each word into two 128-bit beats (low, then zero-padded high).
// Optional read-rate divider enabled by DATAPATH_UNPACK_RD_DIV_EN.
module datapath_unpack_fifo #(
  parameter int IN_DATA_WIDTH  = 192,
  parameter int OUT_DATA_WIDTH = 128,
  parameter int DEPTH          = 512,
  parameter int DEPTH_SIZE     = 9,
  parameter int CLK_DIV        = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [IN_DATA_WIDTH-1:0]  data_in,
  input  logic                      rd,
  output logic [OUT_DATA_WIDTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      beat_sel,
  output logic [DEPTH_SIZE:0]       data_count,
  output logic                      full,
  output logic                      empty,
  output logic                      threshold,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PAD_W = 2 * OUT_DATA_WIDTH - IN_DATA_WIDTH;

  typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [DEPTH_SIZE:0]       w_ptr, r_ptr;
  logic [IN_DATA_WIDTH-1:0]  mem [DEPTH];
  logic                      wr_en, rd_en, rd_tick;
  logic                      load_lo, load_hi, retire;
  logic [DEPTH_SIZE-1:0]     w_addr, r_addr;

  assign w_addr = w_ptr[DEPTH_SIZE-1:0];
  assign r_addr = r_ptr[DEPTH_SIZE-1:0];

  // Modulo subtraction keeps the count correct across pointer wrap.
  assign data_count = w_ptr - r_ptr;
  assign empty      = (data_count == '0);
  assign full       = (data_count == (DEPTH_SIZE+1)'(DEPTH));
  assign threshold  = (data_count >= (DEPTH_SIZE+1)'(DEPTH / 2));
  assign beat_sel   = (state_q == HI);

  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty & rd_tick;

`ifdef DATAPATH_UNPACK_RD_DIV_EN
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else if (div_cnt == DIV_W'(CLK_DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign rd_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
`else
  assign rd_tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    load_lo = 1'b0;
    load_hi = 1'b0;
    retire  = 1'b0;
    case (state_q)
      LO: if (rd_en) begin
        load_lo = 1'b1;
        state_d = HI;
      end
      HI: if (rd_en) begin
        load_hi = 1'b1;
        retire  = 1'b1;
        state_d = LO;
      end
      default: state_d = LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LO;
      w_ptr      <= '0;
      r_ptr      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_valid <= rd_en;
      if (wr_en)
        w_ptr <= w_ptr + 1'b1;
      if (retire)
        r_ptr <= r_ptr + 1'b1;
      // A retiring word frees space, so it outranks a same-cycle overflow.
      if (retire)
        overflow <= 1'b0;
      else if (wr & full)
        overflow <= 1'b1;
      if (wr_en)
        underflow <= 1'b0;
      else if (rd & empty)
        underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[w_addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst)
      data_out <= '0;
    else if (load_lo)
      data_out <= mem[r_addr][OUT_DATA_WIDTH-1:0];
    else if (load_hi)
      data_out <= {{PAD_W{1'b0}}, mem[r_addr][IN_DATA_WIDTH-1:OUT_DATA_WIDTH]};
  end

endmodule

// File: tb/tb_datapath_unpack_fifo.sv
// Bench for datapath_unpack_fifo: queue-of-words reference model, random and directed traffic.
module tb_datapath_unpack_fifo;

  logic         clk = 1'b0;
  logic         rst, wr, rd;
  logic [191:0] data_in;
  logic [127:0] data_out;
  logic         data_valid, beat_sel, full, empty, threshold, overflow, underflow;
  logic [9:0]   data_count;

  datapath_unpack_fifo dut (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .data_valid(data_valid), .beat_sel(beat_sel),
    .data_count(data_count), .full(full), .empty(empty), .threshold(threshold),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: whole words in a queue plus a phase bit for the word at the head.
  logic [191:0] q[$];
  bit           m_hi, m_ov, m_un, m_vld;
  logic [127:0] m_dout;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] rnd192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic compare_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".valid"},  192'(data_valid), 192'(m_vld));
    chk({tag, ".dout"},   192'(data_out),   192'(m_dout));
    chk({tag, ".count"},  192'(data_count), 192'(n));
    chk({tag, ".full"},   192'(full),       192'(n == 512));
    chk({tag, ".empty"},  192'(empty),      192'(n == 0));
    chk({tag, ".thresh"}, 192'(threshold),  192'(n >= 256));
    chk({tag, ".ovf"},    192'(overflow),   192'(m_ov));
    chk({tag, ".unf"},    192'(underflow),  192'(m_un));
    chk({tag, ".beat"},   192'(beat_sel),   192'(m_hi));
  endtask

  task automatic step(input string tag, input bit w, input logic [191:0] d, input bit r);
    bit f, e, wacc, racc, retire;
    @(negedge clk);
    wr = w; data_in = d; rd = r;
    f = (q.size() == 512);
    e = (q.size() == 0);
    wacc = w && !f;
    racc = r && !e;
    retire = racc && m_hi;
    m_vld = racc;
    if (racc) m_dout = m_hi ? {64'h0, q[0][191:128]} : q[0][127:0];
    if (retire) m_ov = 1'b0;
    else if (w && f) m_ov = 1'b1;
    if (wacc) m_un = 1'b0;
    else if (r && e) m_un = 1'b1;
    if (racc) begin
      if (m_hi) void'(q.pop_front());
      m_hi = !m_hi;
    end
    if (wacc) q.push_back(d);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_hi = 0; m_ov = 0; m_un = 0; m_vld = 0; m_dout = '0;
    compare_all(tag);
  endtask

  initial begin
    logic [191:0] tw, w1, w2;
    int pushed, cyc;
    bit w, r;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    do_reset("rst0");
`ifdef DATAPATH_UNPACK_RD_DIV_EN
    begin
      int times[$];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); wr = 1'b1; data_in = rnd192();
      end
      @(negedge clk); wr = 1'b0; rd = 1'b1;
      for (int c = 0; c < 600 && times.size() < 8; c++) begin
        @(posedge clk); #1;
        if (data_valid) times.push_back(c);
      end
      rd = 1'b0;
      chk("div.pulses", 192'(times.size()), 192'(8));
      for (int i = 1; i < times.size(); i++)
        chk("div.spacing", 192'(times[i] - times[i-1]), 192'(30));
    end
`else
    // Basic two-beat unpack of a known word.
    tw = {64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    step("t1.wr", 1, tw, 0);
    step("t1.lo", 0, '0, 1);
    chk("t1.lo_dat", 192'(data_out), 192'({64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}));
    step("t1.hi", 0, '0, 1);
    chk("t1.hi_dat", 192'(data_out), 192'({64'h0, 64'hCCCC_CCCC_CCCC_CCCC}));
    chk("t1.hi_vld", 192'(data_valid), 192'(1));
    step("t1.idle", 0, '0, 0);
    chk("t1.empty", 192'(empty), 192'(1));
    chk("t1.count", 192'(data_count), 192'(0));

    // Fill to capacity, overflow, then a HI read with a refused write.
    for (int i = 0; i < 512; i++) step("t2.fill", 1, rnd192(), 0);
    chk("t2.full", 192'(full), 192'(1));
    chk("t2.thresh", 192'(threshold), 192'(1));
    chk("t2.count", 192'(data_count), 192'(512));
    step("t2.ovf", 1, rnd192(), 0);
    chk("t2.ovf_set", 192'(overflow), 192'(1));
    chk("t2.ovf_cnt", 192'(data_count), 192'(512));
    step("t2.lo", 0, '0, 1);
    step("t2.hi_wr", 1, rnd192(), 1);
    chk("t2.ovf_clr", 192'(overflow), 192'(0));
    chk("t2.cnt511", 192'(data_count), 192'(511));
    for (int i = 0; i < 1100 && q.size() > 0; i++) step("t2.drain", 0, '0, 1);
    chk("t2.drained", 192'(empty), 192'(1));

    // Underflow, cleared by a write; read on empty with same-cycle write is refused.
    step("t3.unf", 0, '0, 1);
    chk("t3.unf_set", 192'(underflow), 192'(1));
    chk("t3.no_vld", 192'(data_valid), 192'(0));
    w1 = rnd192();
    step("t3.wr_rd", 1, w1, 1);
    chk("t3.unf_clr", 192'(underflow), 192'(0));
    chk("t3.refused", 192'(data_valid), 192'(0));
    step("t3.lo", 0, '0, 1);
    chk("t3.lo_dat", 192'(data_out), 192'(w1[127:0]));
    step("t3.hi", 0, '0, 1);

    // Random interleaved traffic across pointer wrap.
    pushed = 0;
    cyc = 0;
    while ((pushed < 1500 || q.size() > 0) && cyc < 20000) begin
      w = (pushed < 1500) && ($urandom_range(3) != 0);
      r = ($urandom_range(2) != 0);
      if (w && q.size() < 512) pushed++;
      step("t4.rand", w, rnd192(), r);
      cyc++;
    end
    chk("t4.pushed", 192'(pushed), 192'(1500));
    chk("t4.empty", 192'(empty), 192'(1));

    // Reset in the middle of a word.
    w1 = rnd192();
    step("t5.wr", 1, w1, 0);
    step("t5.lo", 0, '0, 1);
    chk("t5.beat1", 192'(beat_sel), 192'(1));
    do_reset("t5.rst");
    chk("t5.beat0", 192'(beat_sel), 192'(0));
    chk("t5.empty", 192'(empty), 192'(1));
    chk("t5.dout0", 192'(data_out), 192'(0));
    w2 = rnd192();
    step("t5.wr2", 1, w2, 0);
    step("t5.lo2", 0, '0, 1);
    chk("t5.lo_dat", 192'(data_out), 192'(w2[127:0]));
    step("t5.hi2", 0, '0, 1);
    chk("t5.hi_dat", 192'(data_out), 192'({64'h0, w2[191:128]}));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
